// File: rtl/point_ops_seq.sv
// Sequential point-arithmetic unit: one coordinate per step, restoring divider for DIV.
// Define POINT_OPS_SAT_EN to clamp overflowing ADD/SUB elements instead of wrapping.
module point_ops_seq #(
    parameter int DIM   = 2,
    parameter int WIDTH = 16,
    localparam int OUT_W = 2*WIDTH + 2 + ((DIM > 1) ? $clog2(DIM) : 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [3:0]             io_operation,
    input  logic [DIM*WIDTH-1:0]   io_p1,
    input  logic [DIM*WIDTH-1:0]   io_p2,
    input  logic [WIDTH-1:0]       io_den,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [DIM*WIDTH-1:0]   io_pout,
    output logic [OUT_W-1:0]       io_out,
    output logic                   io_out_err,
    output logic                   io_out_ovf
);
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int BIT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIST2 = 4'd3;
    localparam logic [3:0] OP_MAG2  = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_ELEM, S_DIV, S_DONE} state_t;

    // Returns {overflow, element}; the element wraps or clamps depending on the build.
    function automatic logic [WIDTH:0] fit_elem(input logic signed [WIDTH:0] s);
        logic             ovf;
        logic [WIDTH-1:0] v;
        ovf = s[WIDTH] ^ s[WIDTH-1];
        v   = s[WIDTH-1:0];
`ifdef POINT_OPS_SAT_EN
        if (ovf) v = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {ovf, v};
    endfunction

    state_t                  state;
    logic [3:0]              op_r;
    logic [DIM*WIDTH-1:0]    p1_r, p2_r, work;
    logic [WIDTH-1:0]        den_r, dvd, rem;
    logic [OUT_W-1:0]        acc;
    logic [IDX_W-1:0]        idx;
    logic [BIT_W-1:0]        bcnt;
    logic                    ovf_r;

    logic signed [WIDTH-1:0]     e1, e2;
    logic signed [WIDTH:0]       sum_e, dif_e;
    logic signed [2*WIDTH+1:0]   dif_x, dif_sq;
    logic signed [2*WIDTH-1:0]   e1_x, mag_sq;
    logic [WIDTH:0]              fit;
    logic [WIDTH-1:0]            abs_e, dvd_cur, rem_cur, rem_nx, dvd_nx, q_val, elem_val;
    logic [WIDTH:0]              trial, den_x;
    logic                        ge, is_addsub, idx_last, bit_last;
    logic [DIM*WIDTH-1:0]        work_upd;
    logic [OUT_W-1:0]            acc_upd;

    always_comb begin
        e1        = p1_r[idx*WIDTH +: WIDTH];
        e2        = p2_r[idx*WIDTH +: WIDTH];
        sum_e     = $signed({e1[WIDTH-1], e1}) + $signed({e2[WIDTH-1], e2});
        dif_e     = $signed({e1[WIDTH-1], e1}) - $signed({e2[WIDTH-1], e2});
        dif_x     = (2*WIDTH+2)'(dif_e);
        dif_sq    = dif_x * dif_x;
        e1_x      = (2*WIDTH)'(e1);
        mag_sq    = e1_x * e1_x;
        is_addsub = (op_r == OP_ADD) || (op_r == OP_SUB);
        fit       = fit_elem((op_r == OP_SUB) ? dif_e : sum_e);

        // Restoring divide step; the first bit of each element starts from |p1[i]| and rem=0.
        abs_e   = e1[WIDTH-1] ? ('0 - $unsigned(e1)) : $unsigned(e1);
        dvd_cur = (bcnt == '0) ? abs_e : dvd;
        rem_cur = (bcnt == '0) ? '0 : rem;
        trial   = {rem_cur, dvd_cur[WIDTH-1]};
        den_x   = {1'b0, den_r};
        ge      = (trial >= den_x);
        rem_nx  = ge ? WIDTH'(trial - den_x) : trial[WIDTH-1:0];
        dvd_nx  = {dvd_cur[WIDTH-2:0], ge};
        q_val   = e1[WIDTH-1] ? ('0 - dvd_nx) : dvd_nx;

        elem_val = (op_r == OP_DIV) ? q_val : fit[WIDTH-1:0];
        work_upd = work;
        work_upd[idx*WIDTH +: WIDTH] = elem_val;
        acc_upd  = (op_r == OP_DIST2) ? acc + OUT_W'($unsigned(dif_sq))
                                      : acc + OUT_W'($unsigned(mag_sq));
        idx_last = (idx == IDX_W'(DIM-1));
        bit_last = (bcnt == BIT_W'(WIDTH-1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            io_in_ready  <= 1'b1;
            io_out_valid <= 1'b0;
            io_pout      <= '0;
            io_out       <= '0;
            io_out_err   <= 1'b0;
            io_out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io_in_valid) begin
                        op_r        <= io_operation;
                        p1_r        <= io_p1;
                        p2_r        <= io_p2;
                        den_r       <= io_den;
                        work        <= '0;
                        acc         <= '0;
                        ovf_r       <= 1'b0;
                        idx         <= '0;
                        bcnt        <= '0;
                        io_in_ready <= 1'b0;
                        if (io_operation == OP_DIV) begin
                            state <= S_DIV;
                        end else if (io_operation <= OP_MAG2) begin
                            state <= S_ELEM;
                        end else begin
                            state        <= S_DONE;
                            io_out_valid <= 1'b1;
                            io_pout      <= '0;
                            io_out       <= '0;
                            io_out_err   <= 1'b1;
                            io_out_ovf   <= 1'b0;
                        end
                    end
                end
                S_ELEM: begin
                    if (is_addsub) begin
                        work  <= work_upd;
                        ovf_r <= ovf_r | fit[WIDTH];
                    end else begin
                        acc <= acc_upd;
                    end
                    if (idx_last) begin
                        state        <= S_DONE;
                        io_out_valid <= 1'b1;
                        io_out_err   <= 1'b0;
                        io_pout      <= is_addsub ? work_upd : '0;
                        io_out       <= is_addsub ? '0 : acc_upd;
                        io_out_ovf   <= is_addsub & (ovf_r | fit[WIDTH]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DIV: begin
                    if (den_r == '0) begin
                        state        <= S_DONE;
                        io_out_valid <= 1'b1;
                        io_pout      <= '0;
                        io_out       <= '0;
                        io_out_err   <= 1'b1;
                        io_out_ovf   <= 1'b0;
                    end else begin
                        dvd  <= dvd_nx;
                        rem  <= rem_nx;
                        bcnt <= bit_last ? '0 : bcnt + BIT_W'(1);
                        if (bit_last) begin
                            work <= work_upd;
                            if (idx_last) begin
                                state        <= S_DONE;
                                io_out_valid <= 1'b1;
                                io_pout      <= work_upd;
                                io_out       <= '0;
                                io_out_err   <= 1'b0;
                                io_out_ovf   <= 1'b0;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (io_out_ready) begin
                        state        <= S_IDLE;
                        io_out_valid <= 1'b0;
                        io_in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_point_ops_seq.sv
// Directed bench for point_ops_seq (DIM=2, WIDTH=16): vector table plus backpressure and abort sequences.
module tb_point_ops_seq;
    localparam int DIM   = 2;
    localparam int WIDTH = 16;
    localparam int PW    = DIM*WIDTH;
    localparam int OUT_W = 35;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_in_valid, io_in_ready;
    logic [3:0]        io_operation;
    logic [PW-1:0]     io_p1, io_p2, io_pout;
    logic [WIDTH-1:0]  io_den;
    logic              io_out_valid, io_out_ready;
    logic [OUT_W-1:0]  io_out;
    logic              io_out_err, io_out_ovf;

    always #5 clk = ~clk;

    point_ops_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_operation(io_operation), .io_p1(io_p1), .io_p2(io_p2), .io_den(io_den),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_pout(io_pout), .io_out(io_out), .io_out_err(io_out_err), .io_out_ovf(io_out_ovf)
    );

    typedef struct {
        logic [3:0]       op;
        logic [PW-1:0]    p1;
        logic [PW-1:0]    p2;
        logic [WIDTH-1:0] den;
        int               lat;
        logic [PW-1:0]    pout;
        logic [OUT_W-1:0] out;
        logic             err;
        logic             ovf;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int total = 0;
    int bad   = 0;

    function automatic logic [PW-1:0] pk(input int a, input int b);
        logic [WIDTH-1:0] x, y;
        x = a[WIDTH-1:0];
        y = b[WIDTH-1:0];
        return {y, x};
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                                input int den, input int lat, input logic [PW-1:0] pout,
                                input logic [OUT_W-1:0] out, input logic err, input logic ovf);
        vec_t v;
        v.op = op; v.p1 = p1; v.p2 = p2; v.den = den[WIDTH-1:0]; v.lat = lat;
        v.pout = pout; v.out = out; v.err = err; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!io_out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                         input logic [WIDTH-1:0] den);
        io_in_valid = 1'b1; io_operation = op; io_p1 = p1; io_p2 = p2; io_den = den;
    endtask

    task automatic run_vec(input int i);
        int cyc;
        string tag;
        tag = $sformatf("v%0d", i);
        drive(vecs[i].op, vecs[i].p1, vecs[i].p2, vecs[i].den);
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        check({tag, "_busy"}, 64'(io_in_ready), 64'(0));
        wait_valid(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(vecs[i].lat));
        check({tag, "_pout"}, 64'(io_pout), 64'(vecs[i].pout));
        check({tag, "_out"}, 64'(io_out), 64'(vecs[i].out));
        check({tag, "_err"}, 64'(io_out_err), 64'(vecs[i].err));
        check({tag, "_ovf"}, 64'(io_out_ovf), 64'(vecs[i].ovf));
        @(posedge clk); #1;
        check({tag, "_rdy_after"}, {62'd0, io_in_ready, io_out_valid}, 64'b10);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;
        vecs[0]  = mk(4'd0, pk(3, -4), pk(5, 7), 0, 3, pk(8, 3), '0, 1'b0, 1'b0);
        vecs[1]  = mk(4'd1, pk(10, -5), pk(3, -8), 0, 3, pk(7, 3), '0, 1'b0, 1'b0);
`ifdef POINT_OPS_SAT_EN
        vecs[2]  = mk(4'd0, pk(32767, 0), pk(1, 0), 0, 3, pk(32767, 0), '0, 1'b0, 1'b1);
        vecs[3]  = mk(4'd1, pk(-32768, 5), pk(1, 5), 0, 3, pk(-32768, 0), '0, 1'b0, 1'b1);
`else
        vecs[2]  = mk(4'd0, pk(32767, 0), pk(1, 0), 0, 3, pk(-32768, 0), '0, 1'b0, 1'b1);
        vecs[3]  = mk(4'd1, pk(-32768, 5), pk(1, 5), 0, 3, pk(32767, 0), '0, 1'b0, 1'b1);
`endif
        vecs[4]  = mk(4'd2, pk(-7, 9), '0, 2, 33, pk(-3, 4), '0, 1'b0, 1'b0);
        vecs[5]  = mk(4'd2, pk(100, -100), '0, 7, 33, pk(14, -14), '0, 1'b0, 1'b0);
        vecs[6]  = mk(4'd2, pk(-32768, 32767), '0, 1, 33, pk(-32768, 32767), '0, 1'b0, 1'b0);
        vecs[7]  = mk(4'd2, pk(-7, 9), '0, 0, 2, '0, '0, 1'b1, 1'b0);
        vecs[8]  = mk(4'd7, pk(5, 5), pk(1, 1), 3, 1, '0, '0, 1'b1, 1'b0);
        vecs[9]  = mk(4'd3, pk(1, 2), pk(4, 6), 0, 3, '0, 35'd25, 1'b0, 1'b0);
        vecs[10] = mk(4'd4, pk(-3, 4), pk(9, 9), 0, 3, '0, 35'd25, 1'b0, 1'b0);
        vecs[11] = mk(4'd3, pk(-32768, -32768), pk(32767, 32767), 0, 3, '0, 35'd8589672450, 1'b0, 1'b0);
        vecs[12] = mk(4'd4, pk(-32768, -32768), '0, 0, 3, '0, 35'd2147483648, 1'b0, 1'b0);
        vecs[13] = mk(4'd5, pk(1, 1), pk(1, 1), 1, 1, '0, '0, 1'b1, 1'b0);

        reset = 1'b1; io_in_valid = 1'b0; io_operation = '0; io_p1 = '0; io_p2 = '0;
        io_den = '0; io_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(io_in_ready), 64'(1));
        check("reset_outputs", {26'd0, io_out_valid, io_out_err, io_out_ovf, io_out},
              64'(0));
        check("reset_pout", 64'(io_pout), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: result held while a competing request waits at the input.
        io_out_ready = 1'b0;
        drive(4'd0, pk(1, 2), pk(3, 4), '0);
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        wait_valid(cyc);
        check("bp_lat", 64'(cyc), 64'(3));
        drive(4'd1, pk(9, 9), pk(1, 2), '0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_ctl", k), {62'd0, io_out_valid, io_in_ready}, 64'b10);
            check($sformatf("bp_hold%0d_pout", k), 64'(io_pout), 64'(pk(4, 6)));
        end
        io_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'd0, io_in_ready, io_out_valid}, 64'b10);
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        check("bp_next_accept", 64'(io_in_ready), 64'(0));
        wait_valid(cyc);
        check("bp_next_lat", 64'(cyc), 64'(3));
        check("bp_next_pout", 64'(io_pout), 64'(pk(8, 7)));
        @(posedge clk); #1;

        // Reset in the middle of a divide aborts it with no result.
        drive(4'd2, pk(-7, 9), '0, 16'd2);
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy", {62'd0, io_in_ready, io_out_valid}, 64'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ctl", {62'd0, io_in_ready, io_out_valid}, 64'b10);
        check("abort_pout", 64'(io_pout), 64'(0));
        check("abort_flags", {27'd0, io_out_err, io_out_ovf, io_out}, 64'(0));
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (io_out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/point_ops_seq.md
Name: point_ops_seq

Overview:
- Sequential, handshaked successor to the combinational point-arithmetic unit used by the k-means datapath.
- Generalised to DIM dimensions of WIDTH-bit signed fixed-point integer coordinates.
- Processes one dimension per step, with an iterative divider for centroid averaging (sum / count).
- Sits between the cluster accumulator and the centroid/distance logic; one operation in flight at a time.

Parameters:
- DIM, 2, number of coordinates per point (>=1)
- WIDTH, 16, bits per signed two's-complement coordinate (>=4)
- OUT_W (localparam), 2*WIDTH+2+$clog2(DIM) (min 1 for the clog2 term), width of scalar result

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  1  request valid
- io_in_ready  out  1  unit idle, can accept
- io_operation  in  4  0 ADD, 1 SUB, 2 DIV, 3 DIST2, 4 MAG2; others illegal
- io_p1  in  DIM*WIDTH  point 1; dim i at bits [i*WIDTH +: WIDTH]
- io_p2  in  DIM*WIDTH  point 2
- io_den  in  WIDTH  unsigned divisor for DIV
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts result
- io_pout  out  DIM*WIDTH  vector result (ADD/SUB/DIV)
- io_out  out  OUT_W  unsigned scalar result (DIST2/MAG2)
- io_out_err  out  1  illegal op or divide by zero
- io_out_ovf  out  1  any ADD/SUB element overflowed

Behaviour:
- Reset (sync, active-high):
  - State returns to IDLE; all outputs go to 0 except io_in_ready=1.
  - Reset in any state aborts the operation; no result is emitted.
- FSM states: IDLE, ELEM, DIV, DONE.
- IDLE:
  - io_in_ready=1.
  - Accept on io_in_valid. Capture op, p1, p2 and den; clear the accumulator and flags; set element index to 0.
  - Next state: DIV for op 2; DONE for illegal ops (err=1, all results 0); ELEM otherwise.
- ELEM: one dimension per cycle, index 0..DIM-1.
  - ADD: pout[i] = p1[i] + p2[i].
  - SUB: pout[i] = p1[i] - p2[i].
  - DIST2: acc += (p1[i]-p2[i])^2, with the difference taken at WIDTH+1 bits.
  - MAG2: acc += p1[i]^2.
  - After index DIM-1, go to DONE.
- DIV: restoring divide of |p1[i]| by den, WIDTH cycles per element.
  - Quotient is negated if p1[i] is negative, i.e. truncation toward zero.
  - After the last bit of element DIM-1, go to DONE.
  - den==0: skip the divide entirely, pout=0, err=1, go to DONE the next cycle.
- DONE:
  - io_out_valid=1; io_pout, io_out and flags are held stable.
  - On io_out_ready, go to IDLE and drop io_out_valid.
- Unused result field is 0: io_out=0 for ADD/SUB/DIV; io_pout=0 for DIST2/MAG2.
- Latency (accept edge = cycle 0, io_out_valid first high):
  - ADD/SUB/DIST2/MAG2: cycle DIM+1.
  - DIV: cycle DIM*WIDTH+1.
  - Illegal op or den==0: cycle 1 (den==0: cycle 2).
- No overlap: io_in_ready=0 from the accept cycle until the cycle after the output handshake. A new request can be accepted in the cycle after io_out_valid&&io_out_ready.
- Inputs are ignored outside IDLE; captured values are used throughout.
- Overflow:
  - ADD/SUB per-element signed overflow sets io_out_ovf.
  - DIST2/MAG2 cannot overflow OUT_W.
- Data outputs change only on the transition into DONE or on reset.

Optional Feature:
- Macro: POINT_OPS_SAT_EN.
- Defined: ADD/SUB overflowing elements clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1); io_out_ovf=1.
- Undefined: results wrap modulo 2^WIDTH; io_out_ovf still reports overflow.
- Other ops are unaffected in both cases.

Test Plan:
- DIM=2, WIDTH=16, ADD p1=(3,-4), p2=(5,7), out_ready=1 -> io_out_valid at cycle 3, pout=(8,3), io_out=0, err=0, ovf=0; io_in_ready high at cycle 4.
- DIV p1=(-7,9), den=2 -> io_out_valid at cycle 33, pout=(-3,4); den=0 -> pout=(0,0), err=1 at cycle 2; op=7 -> err=1, all zero at cycle 1.
- DIST2 p1=(1,2), p2=(4,6) -> io_out=25, pout=0; MAG2 p1=(-3,4) -> io_out=25; DIST2 p1=(-32768,-32768), p2=(32767,32767) -> io_out=2*65535^2.
- Backpressure: out_ready=0 for 5 cycles after valid -> outputs stable, io_in_ready=0, a new in_valid is not accepted; raising out_ready completes the handshake and the next request is accepted the following cycle.
- ADD p1=(32767,0), p2=(1,0) -> without macro pout=(-32768,0), ovf=1; with POINT_OPS_SAT_EN pout=(32767,0), ovf=1.
- Reset asserted during DIV (cycle 10) -> next cycle io_in_ready=1, io_out_valid=0, outputs 0, and no result is ever emitted for the aborted op.
